// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter that shares one async-FIFO
// write port among NREQ requesters, all clocked by wclk.
//   wclk, wrst_n      : write clock, async active-low reset
//   req, wdata_req    : per-requester level request and packed data
//   ack               : one-hot per-word accept (combinational)
//   gnt, busy         : registered current owner / grant-active flag
//   wfull, winc, wdata: FIFO write-side handshake
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] wdata_req,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CMAX = CW'(BURST - 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0][DSIZE-1:0] slots;
  logic            in_grant;
  logic            own_req;
  logic            rel;
  logic            found;
  logic [OW-1:0]   win;
  logic [OW-1:0]   cand;

  assign slots    = wdata_req;
  assign in_grant = (state_q == GRANT);
  assign own_req  = req[owner_q];

  assign winc  = in_grant && own_req && !wfull;
  assign ack   = winc ? (ONE << owner_q) : '0;
  assign wdata = in_grant ? slots[owner_q] : '0;
  assign gnt   = gnt_q;
  assign busy  = busy_q;

  // Search starts one past the last winner, so the requester that
  // just released is examined last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = OW'((int'(last_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    unique case (state_q)
      IDLE:    rel = 1'b1;
      GRANT:   rel = !own_req || (winc && cnt_q == CMAX);
      default: rel = 1'b0;
    endcase
    if (rel) begin
      cnt_d = '0;
      if (found) begin
        state_d = GRANT;
        owner_d = win;
        last_d  = win;
      end else begin
        state_d = IDLE;
      end
    end else if (winc) begin
      cnt_d = cnt_q + CW'(1);
    end
    busy_d = (state_d == GRANT);
    gnt_d  = busy_d ? (ONE << owner_d) : '0;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus hand-written
// sequences for BURST=1 wrap-around and async reset mid-burst.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic [3:0]  req = '0;
  logic        wfull = 1'b0;
  logic [31:0] wdata_req;
  logic [3:0]  ack, gnt;
  logic        busy, winc;
  logic [7:0]  wdata;

  logic [3:0]  req1 = '0;
  logic        wfull1 = 1'b0;
  logic [31:0] wdata_req1 = 32'hD3C2B1A0;
  logic [3:0]  ack1, gnt1;
  logic        busy1, winc1;
  logic [7:0]  wdata1;

  logic [7:0]  nacc [4];
  logic [3:0]  ack_s;
  int          ncmp = 0;
  int          nerr = 0;

  fifo_wr_arbiter dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req),
    .wdata_req(wdata_req), .ack(ack), .gnt(gnt),
    .busy(busy), .wfull(wfull), .winc(winc),
    .wdata(wdata)
  );

  fifo_wr_arbiter #(.BURST(1)) dut1 (
    .wclk(wclk), .wrst_n(wrst_n), .req(req1),
    .wdata_req(wdata_req1), .ack(ack1), .gnt(gnt1),
    .busy(busy1), .wfull(wfull1), .winc(winc1),
    .wdata(wdata1)
  );

  always #5 wclk = ~wclk;

  // Requester i presents 0x10*(i+1) + words accepted so far.
  always_comb begin
    wdata_req = '0;
    for (int i = 0; i < 4; i++)
      wdata_req[i*8 +: 8] = 8'((i + 1) * 16) + nacc[i];
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       wf;
    logic [3:0] gnt;
    logic       busy;
    logic       winc;
    logic [3:0] ack;
    logic [7:0] wd;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic rst, input logic [3:0] r, input logic wf,
    input logic [3:0] g, input logic b, input logic w,
    input logic [3:0] a, input logic [7:0] d);
    vec_t v;
    v.rst = rst; v.req = r; v.wf = wf; v.gnt = g;
    v.busy = b; v.winc = w; v.ack = a; v.wd = d;
    vq.push_back(v);
  endfunction

  function automatic void add_rst();
    add(1'b1, 4'b1111, 1'b0, 4'b0, 1'b0, 1'b0, 4'b0, 8'h00);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_nacc();
    for (int j = 0; j < 4; j++) nacc[j] = '0;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    req = '0;
    req1 = '0;
    wfull = 1'b0;
    clr_nacc();
    @(posedge wclk); #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clr_nacc();
    // T1: single requester, two back-to-back bursts
    add_rst();
    add(0, 4'b0001, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    for (int k = 0; k < 8; k++)
      add(0, 4'b0001, 0, 4'b0001, 1, 1, 4'b0001, 8'(16 + k));
    add(0, 4'b0000, 0, 4'b0001, 1, 0, 4'b0000, 8'h18);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    // T2: all four requesting, round robin 0,1,2,3,0
    add_rst();
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        add(0, 4'b1111, 0, 4'(1 << r), 1, 1, 4'(1 << r),
            8'(16 * (r + 1) + k));
    add(0, 4'b1111, 0, 4'b0001, 1, 1, 4'b0001, 8'h14);
    // T3: wfull stall mid-burst of requester 1
    add_rst();
    add(0, 4'b0110, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    add(0, 4'b0110, 0, 4'b0010, 1, 1, 4'b0010, 8'h20);
    add(0, 4'b0110, 0, 4'b0010, 1, 1, 4'b0010, 8'h21);
    for (int k = 0; k < 3; k++)
      add(0, 4'b0110, 1, 4'b0010, 1, 0, 4'b0000, 8'h22);
    add(0, 4'b0110, 0, 4'b0010, 1, 1, 4'b0010, 8'h22);
    add(0, 4'b0110, 0, 4'b0010, 1, 1, 4'b0010, 8'h23);
    add(0, 4'b0110, 0, 4'b0100, 1, 1, 4'b0100, 8'h30);
    // T4: owner 2 withdraws after one word, 3 takes over
    add_rst();
    add(0, 4'b1100, 0, 4'b0000, 0, 0, 4'b0000, 8'h00);
    add(0, 4'b1100, 0, 4'b0100, 1, 1, 4'b0100, 8'h30);
    add(0, 4'b1000, 0, 4'b0100, 1, 0, 4'b0000, 8'h31);
    add(0, 4'b1000, 0, 4'b1000, 1, 1, 4'b1000, 8'h40);
    add(0, 4'b1000, 0, 4'b1000, 1, 1, 4'b1000, 8'h41);

    @(posedge wclk); #1;
    foreach (vq[i]) begin
      wrst_n = !vq[i].rst;
      if (vq[i].rst) clr_nacc();
      req = vq[i].req;
      wfull = vq[i].wf;
      @(negedge wclk);
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vq[i].gnt));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].busy));
      chk($sformatf("v%0d winc", i), 32'(winc), 32'(vq[i].winc));
      chk($sformatf("v%0d ack", i), 32'(ack), 32'(vq[i].ack));
      chk($sformatf("v%0d wdata", i), 32'(wdata), 32'(vq[i].wd));
      ack_s = ack;
      @(posedge wclk); #1;
      for (int j = 0; j < 4; j++)
        if (ack_s[j]) nacc[j] = nacc[j] + 8'd1;
    end
    chk("withdraw acks req2", 32'(nacc[2]), 32'd1);
    chk("withdraw acks req3", 32'(nacc[3]), 32'd2);

    // BURST=1 wrap-around: grants alternate 0,3,0,3
    do_reset();
    req1 = 4'b1001;
    @(negedge wclk);
    chk("b1 idle gnt", 32'(gnt1), 32'd0);
    chk("b1 idle winc", 32'(winc1), 32'd0);
    @(posedge wclk); #1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge wclk);
      chk($sformatf("b1 c%0d gnt", n), 32'(gnt1),
          (n % 2 == 1) ? 32'h1 : 32'h8);
      chk($sformatf("b1 c%0d ack", n), 32'(ack1),
          (n % 2 == 1) ? 32'h1 : 32'h8);
      chk($sformatf("b1 c%0d winc", n), 32'(winc1), 32'd1);
      chk($sformatf("b1 c%0d wdata", n), 32'(wdata1),
          (n % 2 == 1) ? 32'hA0 : 32'hD3);
      @(posedge wclk); #1;
    end

    // Async reset mid-burst (owner 1, cnt 2)
    do_reset();
    req = 4'b0110;
    @(negedge wclk);
    @(posedge wclk); #1;
    for (int n = 0; n < 2; n++) begin
      @(negedge wclk);
      chk($sformatf("ar ack%0d", n), 32'(ack), 32'h2);
      @(posedge wclk); #1;
    end
    @(negedge wclk);
    chk("ar pre winc", 32'(winc), 32'd1);
    #2 wrst_n = 1'b0;
    #1;
    chk("ar winc", 32'(winc), 32'd0);
    chk("ar ack", 32'(ack), 32'd0);
    chk("ar gnt", 32'(gnt), 32'd0);
    chk("ar busy", 32'(busy), 32'd0);
    chk("ar wdata", 32'(wdata), 32'd0);
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    @(negedge wclk);
    chk("ar idle gnt", 32'(gnt), 32'd0);
    chk("ar idle busy", 32'(busy), 32'd0);
    @(posedge wclk); #1;
    @(negedge wclk);
    chk("ar regrant gnt", 32'(gnt), 32'h2);
    chk("ar regrant busy", 32'(busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
